// File: rtl/image_loader.sv
// Byte-stream image loader: captures a width/height header plus raw pixels into
// the convolution processor's data RAM, then enables the processor.
module image_loader #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int MAX_BYTES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              proc_en,
   output logic [15:0]       pix_count
);

   // Handshake: a byte moves on a rising edge when s_valid && s_ready; s_ready is
   // a pure decode of the state register and never looks at s_valid.
   typedef enum logic [2:0] {
      IDLE, HDR_W, HDR_H, CHECK, PIXELS, DONE, ERROR
   } state_t;

   localparam logic [ADDR_W-1:0] HDR_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] PIX_ADDR = ADDR_W'(BASE_ADDR + 2);

   state_t            state;
   logic [DATA_W-1:0] width_r;
   logic [DATA_W-1:0] height_r;
   logic [15:0]       total;
   logic [15:0]       prod;
   logic [31:0]       need;
   logic              xfer;

   assign s_ready = (state == HDR_W) || (state == HDR_H) || (state == PIXELS);
   assign busy    = s_ready || (state == CHECK);
   assign proc_en = done;
   assign xfer    = s_valid && s_ready;
   assign prod    = 16'(width_r) * 16'(height_r);
   assign need    = 32'(prod) + 32'd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         width_r   <= '0;
         height_r  <= '0;
         total     <= '0;
         ram_wen   <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         pix_count <= '0;
      end else begin
         ram_wen <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               // done rises one cycle into DONE, after the last RAM write has retired
               if (state == DONE) done <= 1'b1;
               if (start) begin
                  state     <= HDR_W;
                  pix_count <= '0;
                  done      <= 1'b0;
                  err       <= 1'b0;
               end
            end
            HDR_W: begin
               if (xfer) begin
                  width_r   <= s_data;
                  ram_wen   <= 1'b1;
                  ram_addr  <= HDR_ADDR;
                  ram_wdata <= s_data;
                  state     <= HDR_H;
               end
            end
            HDR_H: begin
               if (xfer) begin
                  height_r  <= s_data;
                  ram_wen   <= 1'b1;
                  ram_addr  <= HDR_ADDR + ADDR_W'(1);
                  ram_wdata <= s_data;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               total <= prod;
               if (width_r == '0 || height_r == '0 || need > 32'(MAX_BYTES)) begin
                  state <= ERROR;
                  err   <= 1'b1;
               end else begin
                  state <= PIXELS;
               end
            end
            PIXELS: begin
               if (xfer) begin
                  ram_wen   <= 1'b1;
                  ram_addr  <= PIX_ADDR + pix_count[ADDR_W-1:0];
                  ram_wdata <= s_data;
                  pix_count <= pix_count + 16'd1;
                  if (pix_count == total - 16'd1) state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: expected RAM writes are queued as bytes
// are handed over and matched against every ram_wen pulse.
module tb_image_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        ram_wen;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        proc_en;
   logic [15:0] pix_count;

   int          vectors = 0;
   int          miscompares = 0;
   int          wen_count = 0;
   logic [19:0] exp_q[$];
   logic [7:0]  mem [0:4095];

   image_loader dut (
      .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .busy(busy), .done(done), .err(err), .proc_en(proc_en), .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RAM model and scoreboard pop, sampled mid-cycle
   always @(negedge clk) begin
      if (ram_wen) begin
         logic [19:0] e;
         wen_count++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(ram_addr), 32'hFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(e[19:8]));
            chk("wr_data", 32'(ram_wdata), 32'(e[7:0]));
         end
         mem[ram_addr] = ram_wdata;
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Present one byte; it is committed on the first edge where s_ready is high.
   task automatic send_byte(input logic [7:0] b, input logic [11:0] addr);
      int t = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         chk("ready_timeout", 32'(s_ready), 32'd1);
      end else begin
         exp_q.push_back({addr, b});
         @(posedge clk);
      end
      #1 s_valid = 1'b0;
   endtask

   task automatic load(input logic [7:0] w, input logic [7:0] h, input logic [7:0] base,
                       input bit gap);
      int n = int'(w) * int'(h);
      send_byte(w, 12'd0);
      if (gap) @(negedge clk);
      send_byte(h, 12'd1);
      for (int i = 0; i < n; i++) begin
         if (gap) @(negedge clk);
         send_byte(base + 8'(i), 12'(2 + i));
      end
   endtask

   task automatic wait_flag(input bit want_err, input int budget);
      int t = 0;
      while (t < budget && !(want_err ? err : done)) begin
         @(negedge clk);
         t++;
      end
      chk(want_err ? "err_wait" : "done_wait", 32'(want_err ? err : done), 32'd1);
   endtask

   initial begin
      int w0;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {s_ready, ram_wen, busy, done, err, proc_en}, 0);
      chk("rst_pix", 32'(pix_count), 0);
      rst = 1'b0;

      // 2x3 back-to-back
      w0 = wen_count;
      pulse_start();
      load(8'h02, 8'h03, 8'h10, 1'b0);
      @(negedge clk);
      chk("done_early", 32'(done), 0);
      @(negedge clk);
      chk("done_on", 32'(done), 1);
      chk("proc_en_on", 32'(proc_en), 1);
      chk("pix_count6", 32'(pix_count), 6);
      chk("wen8", 32'(wen_count - w0), 8);
      chk("idle_ready", {busy, s_ready}, 0);
      chk("mem0", 32'(mem[0]), 32'h02);
      chk("mem1", 32'(mem[1]), 32'h03);
      for (int i = 0; i < 6; i++) chk("mem_pix", 32'(mem[2 + i]), 32'(8'h10 + i));

      // Same image, s_valid toggling
      w0 = wen_count;
      pulse_start();
      @(negedge clk);
      chk("restart_done_low", 32'(done), 0);
      load(8'h02, 8'h03, 8'h10, 1'b1);
      wait_flag(1'b0, 10);
      chk("gap_wen8", 32'(wen_count - w0), 8);
      chk("gap_pix", 32'(pix_count), 6);
      chk("gap_mem7", 32'(mem[7]), 32'h15);

      // Zero width rejected
      w0 = wen_count;
      pulse_start();
      send_byte(8'h00, 12'd0);
      send_byte(8'h05, 12'd1);
      wait_flag(1'b1, 10);
      @(negedge clk) s_valid = 1'b1;
      s_data = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         chk("err_ready", 32'(s_ready), 0);
      end
      s_valid = 1'b0;
      chk("err_wen2", 32'(wen_count - w0), 2);
      chk("err_proc_en", 32'(proc_en), 0);
      chk("err_busy", 32'(busy), 0);
      pulse_start();
      chk("err_cleared", 32'(err), 0);
      load(8'h01, 8'h01, 8'hAA, 1'b0);
      wait_flag(1'b0, 10);
      chk("one_px_mem", 32'(mem[2]), 32'hAA);
      chk("one_px_err", 32'(err), 0);

      // Capacity boundary
      pulse_start();
      send_byte(8'h40, 12'd0);
      send_byte(8'h40, 12'd1);
      wait_flag(1'b1, 10);
      chk("big_done", 32'(done), 0);
      pulse_start();
      load(8'h3F, 8'h40, 8'h5A, 1'b0);
      wait_flag(1'b0, 10);
      chk("big_err", 32'(err), 0);
      chk("big_pix", 32'(pix_count), 4032);
      chk("big_last", 32'(mem[12'hFC1]), 32'(8'(8'h5A + 8'(4031))));

      // Reset in the middle of pixel 3
      pulse_start();
      send_byte(8'h02, 12'd0);
      send_byte(8'h03, 12'd1);
      send_byte(8'h20, 12'd2);
      send_byte(8'h21, 12'd3);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h22;
      #2 rst = 1'b1;
      #1;
      chk("arst_flags", {s_ready, ram_wen, busy, done, err, proc_en}, 0);
      chk("arst_pix", 32'(pix_count), 0);
      chk("arst_addr", {ram_addr, ram_wdata}, 0);
      s_valid = 1'b0;
      w0 = wen_count;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_no_wen", 32'(wen_count - w0), 0);
      pulse_start();
      load(8'h02, 8'h03, 8'h30, 1'b0);
      wait_flag(1'b0, 10);
      chk("arst_reload_mem4", 32'(mem[4]), 32'h32);

      // Start ignored in HDR_H, then start in DONE
      pulse_start();
      send_byte(8'h02, 12'd0);
      pulse_start();
      send_byte(8'h03, 12'd1);
      for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 12'(2 + i));
      wait_flag(1'b0, 10);
      chk("ign_pix", 32'(pix_count), 6);
      chk("ign_mem7", 32'(mem[7]), 32'h45);
      pulse_start();
      chk("redo_done", {done, proc_en}, 0);
      chk("redo_busy", {busy, s_ready}, 3);
      load(8'h04, 8'h01, 8'h50, 1'b0);
      wait_flag(1'b0, 10);
      chk("redo_mem0", 32'(mem[0]), 32'h04);
      chk("redo_mem5", 32'(mem[5]), 32'h53);

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
